red_pitaya_adc_dec: RTL and testbench

Decimating and averaging stage for one fast ADC channel. It sits directly downstream of the analog front-end and consumes the 14-bit two's-complement ADC samples at the full ADC clock rate. It reduces the sample rate by a programmable power-of-two factor and emits one output sample per decimation window, either the window average or the last sample of the window, with a valid strobe. One instance is used per channel, feeding the scope/acquisition buffer.

---
 rtl/red_pitaya_adc_dec_pkg.sv | 43 ++++
 rtl/red_pitaya_adc_dec.sv | 91 +++++++++
 tb/tb_red_pitaya_adc_dec.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/red_pitaya_adc_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : red_pitaya_adc_dec_pkg
// Purpose  : Shared constants and the decimation-factor decoder used by the
//            fast ADC decimation/averaging stage.
// Revision : 1.0 - initial release
// ============================================================================
package red_pitaya_adc_dec_pkg;

  localparam int DW_DEF   = 14;
  localparam int ACCW_DEF = 31;

  localparam logic [16:0] DEC_1     = 17'd1;
  localparam logic [16:0] DEC_8     = 17'd8;
  localparam logic [16:0] DEC_64    = 17'd64;
  localparam logic [16:0] DEC_1024  = 17'd1024;
  localparam logic [16:0] DEC_8192  = 17'd8192;
  localparam logic [16:0] DEC_65536 = 17'd65536;

  typedef struct packed {
    logic       legal;
    logic [4:0] sh;
  } dec_cfg_t;

  // Illegal factors decode to legal=0 with a zero shift (pass-through).
  function automatic dec_cfg_t dec_log2(input logic [16:0] cfg);
    dec_cfg_t r;
    r.legal = 1'b1;
    r.sh    = 5'd0;
    case (cfg)
      DEC_1:     r.sh = 5'd0;
      DEC_8:     r.sh = 5'd3;
      DEC_64:    r.sh = 5'd6;
      DEC_1024:  r.sh = 5'd10;
      DEC_8192:  r.sh = 5'd13;
      DEC_65536: r.sh = 5'd16;
      default:   r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/red_pitaya_adc_dec.sv
`default_nettype none
// ============================================================================
// Module   : red_pitaya_adc_dec
// Purpose  : Power-of-two decimator for one ADC channel; emits the window
//            average or the last window sample with a one-cycle strobe.
// Revision : 1.0 - initial release
// ============================================================================
module red_pitaya_adc_dec
  import red_pitaya_adc_dec_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int ACCW = ACCW_DEF
) (
  input  logic            adc_clk_i,
  input  logic            adc_rst_i,
  input  logic [DW-1:0]   adc_dat_i,
  input  logic            dec_en_i,
  input  logic [16:0]     cfg_dec_i,
  input  logic            cfg_avg_i,
  output logic [DW-1:0]   dec_dat_o,
  output logic            dec_vld_o,
  output logic            cfg_err_o
);

  logic [16:0]            r_cnt;
  logic [16:0]            r_n;
  logic [4:0]             r_sh;
  logic                   r_avg;
  logic signed [ACCW-1:0] r_acc;

  dec_cfg_t               w_cfg;
  logic                   w_start;
  logic                   w_end;
  logic [16:0]            w_n;
  logic [4:0]             w_sh;
  logic                   w_avg;
  logic signed [ACCW-1:0] w_smp;
  logic signed [ACCW-1:0] w_acc_nxt;
  logic [DW-1:0]          w_dat_nxt;

  // On a window-start cycle the freshly decoded config already governs that
  // cycle, so a window of N=1 can end on the same cycle it starts.
  always_comb begin
    w_cfg   = dec_log2(cfg_dec_i);
    w_start = (r_cnt == 17'd0);
    w_n     = r_n;
    w_sh    = r_sh;
    w_avg   = r_avg;
    if (w_start) begin
      w_n   = w_cfg.legal ? cfg_dec_i : DEC_1;
      w_sh  = w_cfg.sh;
      w_avg = cfg_avg_i;
    end
    w_end     = (r_cnt == (w_n - 17'd1));
    w_smp     = {{(ACCW-DW){adc_dat_i[DW-1]}}, adc_dat_i};
    w_acc_nxt = w_start ? w_smp : (r_acc + w_smp);
    w_dat_nxt = w_avg ? DW'(w_acc_nxt >>> w_sh) : adc_dat_i;
  end

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_n       <= DEC_1;
      r_sh      <= 5'd0;
      r_avg     <= 1'b0;
      dec_dat_o <= '0;
      dec_vld_o <= 1'b0;
      cfg_err_o <= 1'b0;
    end else if (!dec_en_i) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      dec_vld_o <= 1'b0;
    end else begin
      if (w_start) begin
        r_n       <= w_n;
        r_sh      <= w_sh;
        r_avg     <= w_avg;
        cfg_err_o <= ~w_cfg.legal;
      end
      r_acc     <= w_acc_nxt;
      r_cnt     <= w_end ? 17'd0 : (r_cnt + 17'd1);
      dec_vld_o <= w_end;
      if (w_end) begin
        dec_dat_o <= w_dat_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_adc_dec.sv
`default_nettype none
// ============================================================================
// Module   : tb_red_pitaya_adc_dec
// Purpose  : Directed self-checking bench for red_pitaya_adc_dec.
// Revision : 1.0 - initial release
// ============================================================================
module tb_red_pitaya_adc_dec;

  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          avg;
  logic [16:0]   cfg;
  logic [DW-1:0] dat;
  logic [DW-1:0] dec_dat;
  logic          vld;
  logic          err;

  int checks  = 0;
  int errors  = 0;
  int vld_cnt = 0;

  always #4 clk = ~clk;

  red_pitaya_adc_dec #(.DW(DW), .ACCW(31)) dut (
    .adc_clk_i (clk),
    .adc_rst_i (rst),
    .adc_dat_i (dat),
    .dec_en_i  (en),
    .cfg_dec_i (cfg),
    .cfg_avg_i (avg),
    .dec_dat_o (dec_dat),
    .dec_vld_o (vld),
    .cfg_err_o (err)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int d);
    dat = DW'(d);
    @(posedge clk);
    #1;
    if (vld === 1'b1) vld_cnt++;
  endtask

  task automatic run(input int n, input int d);
    for (int i = 0; i < n; i++) tick(d);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg = 17'd1; avg = 1'b0; dat = '0;

    // Reset state
    run(2, 0);
    chk("rst_dat", $signed(dec_dat), 0);
    chk("rst_vld", {31'd0, vld}, 0);
    chk("rst_err", {31'd0, err}, 0);

    // Pass-through N=1
    rst = 1'b0; en = 1'b1; cfg = 17'd1; avg = 1'b1;
    tick(100);   chk("pt_vld0", {31'd0, vld}, 1); chk("pt_dat0", $signed(dec_dat), 100);
    tick(-5);    chk("pt_vld1", {31'd0, vld}, 1); chk("pt_dat1", $signed(dec_dat), -5);
    tick(8191);  chk("pt_vld2", {31'd0, vld}, 1); chk("pt_dat2", $signed(dec_dat), 8191);
    tick(-8192); chk("pt_vld3", {31'd0, vld}, 1); chk("pt_dat3", $signed(dec_dat), -8192);

    // Ramp average N=8
    cfg = 17'd8; avg = 1'b1; vld_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      tick(i);
      if (i == 0) chk("ramp_hold", $signed(dec_dat), -8192);
    end
    chk("ramp_nostb", vld_cnt, 0);
    tick(7); chk("ramp_vld", {31'd0, vld}, 1); chk("ramp_dat", $signed(dec_dat), 3);

    // Floor rounding: 7 x 0 then -1 -> -1, strobe 8 cycles after previous
    vld_cnt = 0;
    run(7, 0);
    chk("floor_nostb", vld_cnt, 0);
    chk("floor_hold", $signed(dec_dat), 3);
    tick(-1); chk("floor_vld", {31'd0, vld}, 1); chk("floor_dat", $signed(dec_dat), -1);

    // Last-sample mode N=64, config change mid-window
    cfg = 17'd64; avg = 1'b0; vld_cnt = 0;
    for (int i = 0; i < 63; i++) begin
      if (i == 10) cfg = 17'd8;
      tick(i);
    end
    chk("last_nostb", vld_cnt, 0);
    tick(63); chk("last_vld", {31'd0, vld}, 1); chk("last_dat", $signed(dec_dat), 63);
    vld_cnt = 0;
    for (int i = 0; i < 7; i++) tick(100 + i);
    chk("newcfg_nostb", vld_cnt, 0);
    tick(107); chk("newcfg_vld", {31'd0, vld}, 1); chk("newcfg_dat", $signed(dec_dat), 107);

    // Illegal configuration
    cfg = 17'd10; avg = 1'b1;
    tick(55); chk("ill_err", {31'd0, err}, 1); chk("ill_vld", {31'd0, vld}, 1);
    chk("ill_dat", $signed(dec_dat), 55);
    tick(-7); chk("ill_dat2", $signed(dec_dat), -7);
    cfg = 17'd8;
    tick(0); chk("fix_err", {31'd0, err}, 0); chk("fix_vld", {31'd0, vld}, 0);
    vld_cnt = 0;
    run(6, 16);
    chk("fix_nostb", vld_cnt, 0);
    tick(16); chk("fix_vld2", {31'd0, vld}, 1); chk("fix_dat", $signed(dec_dat), 14);

    // Full scale, maximum shift
    cfg = 17'd65536; avg = 1'b1; vld_cnt = 0;
    run(65535, -8192);
    chk("fsn_nostb", vld_cnt, 0);
    tick(-8192); chk("fsn_vld", {31'd0, vld}, 1); chk("fsn_dat", $signed(dec_dat), -8192);
    cfg = 17'd8192; vld_cnt = 0;
    run(8191, 8191);
    chk("fsp_nostb", vld_cnt, 0);
    tick(8191); chk("fsp_vld", {31'd0, vld}, 1); chk("fsp_dat", $signed(dec_dat), 8191);

    // Abort mid-window at sample 500, then re-enable
    cfg = 17'd1024; avg = 1'b1; vld_cnt = 0;
    run(500, 1);
    en = 1'b0;
    tick(1); chk("abort_vld", {31'd0, vld}, 0); chk("abort_hold", $signed(dec_dat), 8191);
    run(3, 1);
    chk("abort_nostb", vld_cnt, 0);
    en = 1'b1; vld_cnt = 0;
    run(1023, 2);
    chk("reen_nostb", vld_cnt, 0);
    tick(2); chk("reen_vld", {31'd0, vld}, 1); chk("reen_dat", $signed(dec_dat), 2);

    // Reset mid-window
    cfg = 17'd8; avg = 1'b0;
    run(3, 5);
    rst = 1'b1;
    tick(5); chk("mrst_dat", $signed(dec_dat), 0); chk("mrst_vld", {31'd0, vld}, 0);

    // Reset clears an illegal-config error
    rst = 1'b0; cfg = 17'd3;
    tick(5); chk("ill2_err", {31'd0, err}, 1); chk("ill2_dat", $signed(dec_dat), 5);
    rst = 1'b1;
    tick(5); chk("rst2_err", {31'd0, err}, 0); chk("rst2_vld", {31'd0, vld}, 0);
    chk("rst2_dat", $signed(dec_dat), 0);

    // First window after reset release
    rst = 1'b0; cfg = 17'd8; avg = 1'b0; vld_cnt = 0;
    run(7, 9);
    chk("rel_nostb", vld_cnt, 0);
    tick(9); chk("rel_vld", {31'd0, vld}, 1); chk("rel_dat", $signed(dec_dat), 9);

    // Enable dropped on the final sample of a window
    vld_cnt = 0;
    run(7, 4);
    en = 1'b0;
    tick(4); chk("endrop_vld", {31'd0, vld}, 0); chk("endrop_hold", $signed(dec_dat), 9);
    chk("endrop_nostb", vld_cnt, 0);
    en = 1'b1; vld_cnt = 0;
    run(7, 6);
    chk("endrop_re_nostb", vld_cnt, 0);
    tick(6); chk("endrop_re_vld", {31'd0, vld}, 1); chk("endrop_re_dat", $signed(dec_dat), 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
